pdm_sdm_tx: RTL and testbench

- PDM transmitter: converts a stream of signed 17-bit PCM samples into a 1-bit pulse-density stream plus the matching PDM bit clock, using a 2nd-order delta-sigma modulator.
- It is the generating end of the microphone PDM link. It emulates a MEMS mic for self-test and bench loopback into the mic-array decimation chain (CIC/halfband/FIR).
- Single system clock. The PDM clock is generated internally from a divide counter, not from a derived clock.

---
 rtl/pdm_pkg.sv | 29 ++
 rtl/pdm_sdm_tx_if.sv | 23 ++
 rtl/pdm_sdm2.sv | 71 +++++++
 rtl/pdm_sdm_tx.sv | 138 +++++++++++++
 tb/tb_pdm_sdm_tx.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM transmitter: full-scale and clamp levels,
// default modulator integrator width, FSM state encoding and the input clamp.
package pdm_pkg;

    // PCM full scale (2^(W-1) for W = 17); also the modulator feedback magnitude
    localparam int FS        = 65536;
    // Modulator input limit, 0.75 FS, keeps the 2nd-order loop stable
    localparam int CLAMP_POS = 49152;
    localparam int CLAMP_NEG = -49152;
    // Default integrator width
    localparam int unsigned IW = 24;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Limit a sample to the stable modulator input range
    function automatic int clamp_xs(input int x);
        if (x > CLAMP_POS) begin
            return CLAMP_POS;
        end
        if (x < CLAMP_NEG) begin
            return CLAMP_NEG;
        end
        return x;
    endfunction

endpackage

// File: rtl/pdm_sdm_tx_if.sv
// PCM sample stream into the PDM transmitter (valid/ready handshake).
//   x_in    : signed PCM sample, W bits
//   x_valid : sample offered by the source
//   x_ready : transmitter holding register is empty
interface pdm_sdm_tx_if #(
    parameter int unsigned W = 17
);
    logic signed [W-1:0] x_in;
    logic                x_valid;
    logic                x_ready;

    modport master (
        output x_in,
        output x_valid,
        input  x_ready
    );

    modport slave (
        input  x_in,
        input  x_valid,
        output x_ready
    );
endinterface

// File: rtl/pdm_sdm2.sv
// Second-order delta-sigma modulator core.
//   CLK, RST : system clock, asynchronous active-high reset
//   step     : advance the modulator by one PDM bit
//   clear    : zero both integrators and the output bit
//   xs       : modulator input (already clamped), signed IW bits
//   pdm_bit  : registered output bit, also the feedback for the next step
module pdm_sdm2 #(
    parameter int unsigned IW = pdm_pkg::IW
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 step,
    input  logic                 clear,
    input  logic signed [IW-1:0] xs,
    output logic                 pdm_bit
);
    import pdm_pkg::*;

    // Two guard bits cover integrator + input + feedback without overflow
    localparam int unsigned SW = IW + 2;
    localparam logic signed [IW-1:0] IMAX   = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMAX   = SW'(IMAX);
    localparam logic signed [SW-1:0] SMIN   = -SMAX;
    localparam logic signed [SW-1:0] FB_MAG = SW'(FS);

    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic signed [IW-1:0] i1n_c;
    logic signed [IW-1:0] i2n_c;
    logic signed [SW-1:0] fb_c;
    logic signed [SW-1:0] s1_c;
    logic signed [SW-1:0] s2_c;

    // Symmetric saturation to +-(2^(IW-1)-1); integrators never wrap
    function automatic logic signed [IW-1:0] sat_iw(input logic signed [SW-1:0] v);
        if (v > SMAX) begin
            return IMAX;
        end
        if (v < SMIN) begin
            return -IMAX;
        end
        return IW'(v);
    endfunction

    // Next integrator values; feedback is the previously emitted bit
    always_comb begin
        fb_c  = pdm_bit ? FB_MAG : -FB_MAG;
        s1_c  = SW'(i1) + SW'(xs) - fb_c;
        i1n_c = sat_iw(s1_c);
        s2_c  = SW'(i2) + SW'(i1n_c) - fb_c;
        i2n_c = sat_iw(s2_c);
    end

    // Integrator and output-bit state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            i1      <= '0;
            i2      <= '0;
            pdm_bit <= 1'b0;
        end else if (clear) begin
            i1      <= '0;
            i2      <= '0;
            pdm_bit <= 1'b0;
        end else if (step) begin
            i1      <= i1n_c;
            i2      <= i2n_c;
            pdm_bit <= ~i2n_c[IW-1];
        end
    end

endmodule

// File: rtl/pdm_sdm_tx.sv
// PDM transmitter: turns a stream of signed PCM samples into a 1-bit PDM
// stream plus its bit clock, emulating a MEMS microphone.
//   CLK, RST     : system clock, asynchronous active-high reset
//   enable       : run request; dropping it returns to IDLE next cycle
//   xs_if        : PCM sample handshake (slave), one-entry holding register
//   pdm_clk      : PDM bit clock, DIV system clocks per period, DIV/2 high
//   pdm_out      : PDM data, updated in the cycle pdm_clk falls
//   underrun     : one-cycle pulse when a sample boundary finds no sample
//   underrun_cnt : saturating count of underruns
module pdm_sdm_tx #(
    parameter int unsigned DIV = 8,
    parameter int unsigned OSR = 64,
    parameter int unsigned W   = 17,
    parameter int unsigned IW  = pdm_pkg::IW
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    pdm_sdm_tx_if.slave xs_if,
    output logic        pdm_clk,
    output logic        pdm_out,
    output logic        underrun,
    output logic [7:0]  underrun_cnt
);
    import pdm_pkg::*;

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CW-1:0] CNT_RISE = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(OSR - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bitcnt;
    logic signed [W-1:0] hold;
    logic signed [W-1:0] cur;
    logic                hold_empty;

    logic                run_c;
    logic                tick_c;
    logic                boundary_c;
    logic                clear_c;
    logic signed [IW-1:0] xs_c;

    // Bit tick is the cycle pdm_clk falls; the last tick of a frame is a boundary
    assign run_c      = (state == RUN) && enable;
    assign tick_c     = run_c && (cnt == CNT_LAST);
    assign boundary_c = tick_c && (bitcnt == BIT_LAST);
    // Integrators are held clear whenever not actively running
    assign clear_c    = ~run_c;
    assign xs_c       = IW'(clamp_xs(int'(cur)));

    assign xs_if.x_ready = hold_empty;

    // Modulator core
    pdm_sdm2 #(
        .IW (IW)
    ) u_sdm (
        .CLK     (CLK),
        .RST     (RST),
        .step    (tick_c),
        .clear   (clear_c),
        .xs      (xs_c),
        .pdm_bit (pdm_out)
    );

    // FSM, bit-clock divider, frame counter, holding register and underrun
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            bitcnt       <= '0;
            hold         <= '0;
            cur          <= '0;
            hold_empty   <= 1'b1;
            pdm_clk      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;

            // Accept only while empty, so it never collides with a consume
            if (xs_if.x_valid && hold_empty) begin
                hold       <= xs_if.x_in;
                hold_empty <= 1'b0;
            end

            case (state)
                IDLE: begin
                    pdm_clk <= 1'b0;
                    cnt     <= '0;
                    bitcnt  <= '0;
                    if (enable && !hold_empty) begin
                        cur        <= hold;
                        hold_empty <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        // Hold register is kept across the stop
                        state   <= IDLE;
                        pdm_clk <= 1'b0;
                        cnt     <= '0;
                        bitcnt  <= '0;
                    end else begin
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                        if (cnt == CNT_RISE) begin
                            pdm_clk <= 1'b1;
                        end else if (cnt == CNT_LAST) begin
                            pdm_clk <= 1'b0;
                        end
                        if (tick_c) begin
                            bitcnt <= boundary_c ? '0 : bitcnt + BW'(1);
                        end
                        if (boundary_c) begin
                            if (!hold_empty) begin
                                cur        <= hold;
                                hold_empty <= 1'b1;
                            end else begin
                                // Starved: previous sample repeats
                                underrun <= 1'b1;
                                if (underrun_cnt != 8'hFF) begin
                                    underrun_cnt <= underrun_cnt + 8'd1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_sdm_tx.sv
// Directed self-checking bench for pdm_sdm_tx.
module tb_pdm_sdm_tx;

    localparam int DIV = 8;

    logic CLK = 1'b0;
    logic RST;
    logic enable;
    logic pdm_clk, pdm_out, underrun;
    logic [7:0] underrun_cnt;

    logic en2;
    logic pdm_clk2, pdm_out2, underrun2;
    logic [7:0] underrun_cnt2;

    pdm_sdm_tx_if #(.W(17)) xs_if ();
    pdm_sdm_tx_if #(.W(17)) xs_if2 ();

    pdm_sdm_tx #(.DIV(8), .OSR(64), .W(17), .IW(24)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (enable),
        .xs_if        (xs_if),
        .pdm_clk      (pdm_clk),
        .pdm_out      (pdm_out),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    // Small instance so the saturating counter is reachable quickly
    pdm_sdm_tx #(.DIV(4), .OSR(2), .W(17), .IW(24)) dut2 (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (en2),
        .xs_if        (xs_if2),
        .pdm_clk      (pdm_clk2),
        .pdm_out      (pdm_out2),
        .underrun     (underrun2),
        .underrun_cnt (underrun_cnt2)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic bitbuf [0:255];
    logic undbuf [0:255];
    logic ref_bits [0:63];
    int nbit;
    int first_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic int ones(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += (bitbuf[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    function automatic int unders(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += (undbuf[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    // Capture nbits PDM bits at pdm_clk falling samples; optionally check clock shape
    task automatic collect(input int nbits, input bit chk);
        int cyc;
        int last_rise;
        logic pc, po;
        cyc = 0;
        last_rise = -1;
        nbit = 0;
        first_cyc = -1;
        pc = pdm_clk;
        po = pdm_out;
        while (nbit < nbits && cyc < nbits * DIV + 4 * DIV) begin
            @(posedge CLK); #1;
            cyc++;
            if (chk && (pdm_out !== po))
                check("out_edge", 32'(pc && !pdm_clk), 32'd1);
            if (!pc && pdm_clk) begin
                if (chk && last_rise >= 0)
                    check("clk_period", 32'(cyc - last_rise), 32'(DIV));
                last_rise = cyc;
            end
            if (pc && !pdm_clk) begin
                if (chk && last_rise >= 0)
                    check("clk_high", 32'(cyc - last_rise), 32'(DIV / 2));
                if (nbit == 0) first_cyc = cyc;
                bitbuf[nbit] = pdm_out;
                undbuf[nbit] = underrun;
                nbit++;
            end
            pc = pdm_clk;
            po = pdm_out;
        end
        check("bit_count", 32'(nbit), 32'(nbits));
    endtask

    task automatic push(input logic signed [16:0] v);
        int n = 0;
        while (xs_if.x_ready !== 1'b1 && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
        check("push_ready", 32'(xs_if.x_ready), 32'd1);
        xs_if.x_in = v;
        xs_if.x_valid = 1'b1;
        @(posedge CLK); #1;
        xs_if.x_valid = 1'b0;
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        enable = 1'b0;
        xs_if.x_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        logic [7:0] p;
        int n;
        int diffs;

        RST = 1'b1;
        enable = 1'b0;
        en2 = 1'b0;
        xs_if.x_in = '0;
        xs_if.x_valid = 1'b0;
        xs_if2.x_in = '0;
        xs_if2.x_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
        check("rst_pdm_out", 32'(pdm_out), 32'd0);
        check("rst_x_ready", 32'(xs_if.x_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_ur_cnt", 32'(underrun_cnt), 32'd0);
        RST = 1'b0;

        // x = 0, continuous samples: clock shape, exact start pattern, density
        xs_if.x_in = 17'sd0;
        xs_if.x_valid = 1'b1;
        enable = 1'b1;
        collect(128, 1'b1);
        for (int i = 0; i < 8; i++) p[i] = bitbuf[i];
        // From zero integrators: bits 1,1,0,1,0,0,1,1 (bit 0 first)
        check("x0_first8", 32'(p), 32'(8'b1100_1011));
        check_range("x0_density", ones(64, 127), 31, 33);
        check("x0_no_underrun", 32'(unders(0, 127)), 32'd0);

        // x = +0.5 FS
        reset_dut();
        xs_if.x_in = 17'sd32768;
        xs_if.x_valid = 1'b1;
        enable = 1'b1;
        collect(128, 1'b0);
        check_range("xpos_density", ones(64, 127), 46, 50);

        // x = -0.5 FS
        reset_dut();
        xs_if.x_in = -17'sd32768;
        xs_if.x_valid = 1'b1;
        enable = 1'b1;
        collect(128, 1'b0);
        check_range("xneg_density", ones(64, 127), 14, 18);

        // Clamp: +65535 must produce the same stream as +49152
        reset_dut();
        xs_if.x_in = 17'sd65535;
        xs_if.x_valid = 1'b1;
        enable = 1'b1;
        collect(64, 1'b0);
        for (int i = 0; i < 64; i++) ref_bits[i] = bitbuf[i];
        reset_dut();
        xs_if.x_in = 17'sd49152;
        xs_if.x_valid = 1'b1;
        enable = 1'b1;
        collect(64, 1'b0);
        diffs = 0;
        for (int i = 0; i < 64; i++) diffs += (bitbuf[i] !== ref_bits[i]) ? 1 : 0;
        check("clamp_stream_diffs", 32'(diffs), 32'd0);

        // Underrun: two samples then starve
        reset_dut();
        enable = 1'b1;
        push(-17'sd32768);
        push(17'sd32768);
        collect(128, 1'b0);
        check("ur_none_first", 32'(unders(0, 126)), 32'd0);
        check("ur_at_boundary2", 32'(undbuf[127]), 32'd1);
        @(posedge CLK); #1;
        check("ur_one_cycle", 32'(underrun), 32'd0);
        check("ur_cnt_1", 32'(underrun_cnt), 32'd1);
        check("ur_ready", 32'(xs_if.x_ready), 32'd1);
        collect(64, 1'b0);
        check_range("ur_repeat_density", ones(0, 63), 46, 50);
        check("ur_cnt_2", 32'(underrun_cnt), 32'd2);

        // Asynchronous reset mid-run
        push(17'sd0);
        check("pre_rst_ready", 32'(xs_if.x_ready), 32'd0);
        n = 0;
        while (!(pdm_clk === 1'b1 && pdm_out === 1'b1) && n < 400) begin
            @(posedge CLK); #1;
            n++;
        end
        check("pre_rst_clk_out_high", 32'(pdm_clk && pdm_out), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_pdm_clk", 32'(pdm_clk), 32'd0);
        check("arst_pdm_out", 32'(pdm_out), 32'd0);
        check("arst_x_ready", 32'(xs_if.x_ready), 32'd1);
        check("arst_ur_cnt", 32'(underrun_cnt), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            n += (pdm_clk !== 1'b0) ? 1 : 0;
        end
        check("idle_without_sample", 32'(n), 32'd0);

        // Enable drop mid-frame, then re-enable with a held sample
        push(17'sd0);
        push(17'sd0);
        collect(10, 1'b0);
        n = 0;
        while (pdm_clk !== 1'b1 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("drop_clk_was_high", 32'(pdm_clk), 32'd1);
        enable = 1'b0;
        @(posedge CLK); #1;
        check("drop_pdm_clk", 32'(pdm_clk), 32'd0);
        check("drop_pdm_out", 32'(pdm_out), 32'd0);
        check("drop_hold_kept", 32'(xs_if.x_ready), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        enable = 1'b1;
        collect(64, 1'b0);
        // One cycle to leave IDLE, then DIV clocks to the first bit
        check("reen_first_bit_lat", 32'(first_cyc), 32'(1 + DIV));
        for (int i = 0; i < 8; i++) p[i] = bitbuf[i];
        check("reen_first8", 32'(p), 32'(8'b1100_1011));
        check("reen_no_early_ur", 32'(unders(0, 62)), 32'd0);
        check("reen_ur_bit63", 32'(undbuf[63]), 32'd1);

        // Saturating underrun counter on the small instance (~300 boundaries)
        en2 = 1'b1;
        xs_if2.x_in = 17'sd0;
        xs_if2.x_valid = 1'b1;
        @(posedge CLK); #1;
        xs_if2.x_valid = 1'b0;
        repeat (2420) @(posedge CLK);
        #1;
        check("ur_cnt_saturate", 32'(underrun_cnt2), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
